// File: rtl/rxn_player_pkg.sv
// Shared types for the rxn stimulus player: time/value formats and the queued event record.
// Fractional points (TIME_POINT, FILTER_OUT_POINT) only affect interpretation, never the logic here.
package rxn_player_pkg;

    localparam int TIME_W       = 32;
    localparam int FILTER_OUT_W = 16;

    typedef logic [TIME_W-1:0]              time_format_t;
    typedef logic signed [FILTER_OUT_W-1:0] filter_out_format_t;

    // "time" is a reserved word, so the timestamp member is called stamp.
    typedef struct packed {
        time_format_t       stamp;
        filter_out_format_t value;
    } rxn_event_t;

endpackage

// File: rtl/rxn_player_event_fifo.sv
// Synchronous event FIFO with head and second-entry read ports; full/empty come from the count.
// The full flag is registered so the loader handshake never depends on same-cycle pops.
module rxn_player_event_fifo
    import rxn_player_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  rxn_event_t               push_data,
    input  logic                     pop,
    output rxn_event_t               head,
    output rxn_event_t               second,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    rxn_event_t      mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic            full_r;
    logic            do_push_s;
    logic            do_pop_s;
    logic [CW-1:0]   count_next_s;

    // Qualify push/pop against the registered occupancy and compute the next count.
    always_comb begin
        do_push_s    = push && !full_r && !clear;
        do_pop_s     = pop && (count_r != {CW{1'b0}}) && !clear;
        count_next_s = count_r;
        case ({do_push_s, do_pop_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Pointers, occupancy and the registered full flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            full_r   <= 1'b0;
        end else if (clear) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            full_r   <= 1'b0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == CW'(DEPTH));
        end
    end

    // Storage array; contents are meaningless outside the occupied window, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign head   = mem_r[rd_ptr_r];
    assign second = mem_r[rd_ptr_r + AW'(1)];
    assign count  = count_r;
    assign full   = full_r;

endmodule

// File: rtl/rxn_player.sv
// Stimulus player: queues (time, value) events and replays them as a piecewise-constant
// waveform as emulated time passes each event's timestamp.
module rxn_player
    import rxn_player_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic [TIME_W-1:0]         time_in,
    input  logic                      time_valid,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [TIME_W-1:0]         load_time,
    input  logic [FILTER_OUT_W-1:0]   load_value,
    output logic [FILTER_OUT_W-1:0]   value_out,
    output logic                      value_update,
    output logic [$clog2(DEPTH):0]    events_pending,
    output logic                      late_error,
    output logic                      order_error
);

    localparam int CW = $clog2(DEPTH) + 1;

    rxn_event_t          head_s;
    rxn_event_t          second_s;
    rxn_event_t          load_event_s;
    logic [CW-1:0]       count_s;
    logic                full_s;
    logic                accept_s;
    logic                order_ok_s;
    logic                push_s;
    logic                pop_s;
    logic                late_s;

    time_format_t        last_time_r;
    logic                have_last_r;
    filter_out_format_t  value_out_r;
    logic                value_update_r;
    logic                late_error_r;
    logic                order_error_r;

    // Handshake, ordering check and pop/late decisions for this cycle.
    always_comb begin
        load_event_s.stamp = load_time;
        load_event_s.value = load_value;
        accept_s   = load_valid && !full_s && !clear;
        order_ok_s = !have_last_r || (load_time > last_time_r);
        push_s     = accept_s && order_ok_s;
        pop_s      = time_valid && !clear && (count_s != {CW{1'b0}})
                     && (head_s.stamp <= time_in);
        late_s     = pop_s && (count_s > CW'(1)) && (second_s.stamp <= time_in);
    end

    rxn_player_event_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .push      (push_s),
        .push_data (load_event_s),
        .pop       (pop_s),
        .head      (head_s),
        .second    (second_s),
        .count     (count_s),
        .full      (full_s)
    );

    // Ordering history, replayed value and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_time_r    <= {TIME_W{1'b0}};
            have_last_r    <= 1'b0;
            value_out_r    <= {FILTER_OUT_W{1'b0}};
            value_update_r <= 1'b0;
            late_error_r   <= 1'b0;
            order_error_r  <= 1'b0;
        end else if (clear) begin
            last_time_r    <= {TIME_W{1'b0}};
            have_last_r    <= 1'b0;
            value_out_r    <= {FILTER_OUT_W{1'b0}};
            value_update_r <= 1'b0;
            late_error_r   <= 1'b0;
            order_error_r  <= 1'b0;
        end else begin
            // Only queued events advance the ordering history; dropped ones do not.
            if (push_s) begin
                last_time_r <= load_time;
                have_last_r <= 1'b1;
            end
            if (pop_s) begin
                value_out_r <= head_s.value;
            end
            value_update_r <= pop_s;
            late_error_r   <= late_error_r | late_s;
            order_error_r  <= order_error_r | (accept_s && !order_ok_s);
        end
    end

    assign load_ready     = !full_s;
    assign value_out      = value_out_r;
    assign value_update   = value_update_r;
    assign events_pending = count_s;
    assign late_error     = late_error_r;
    assign order_error    = order_error_r;

endmodule

// File: tb/tb_rxn_player.sv
// Directed bench for rxn_player (DEPTH=4): replay, full/wrap, late, order, gating, clear, reset.
module tb_rxn_player;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic [31:0] time_in;
    logic        time_valid;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_time;
    logic [15:0] load_value;
    logic [15:0] value_out;
    logic        value_update;
    logic [2:0]  events_pending;
    logic        late_error;
    logic        order_error;

    int total_checks = 0;
    int pass_checks  = 0;
    int upd_count    = 0;

    rxn_player #(.DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear          (clear),
        .time_in        (time_in),
        .time_valid     (time_valid),
        .load_valid     (load_valid),
        .load_ready     (load_ready),
        .load_time      (load_time),
        .load_value     (load_value),
        .value_out      (value_out),
        .value_update   (value_update),
        .events_pending (events_pending),
        .late_error     (late_error),
        .order_error    (order_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_checks++;
        assert (obs === exp) pass_checks++;
        else $error("FAIL %s: got %0h, required %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] v16(input logic [15:0] x);
        return {16'h0000, x};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic load(input logic [31:0] t, input logic [15:0] v);
        load_valid = 1'b1;
        load_time  = t;
        load_value = v;
        tick();
        load_valid = 1'b0;
    endtask

    // Leaves 3 pending events, both error flags set and value_out = 7.
    task automatic build_dirty();
        do_clear();
        load(32'd5, 16'd7);
        load(32'd6, 16'd8);
        load(32'd4, 16'd9);
        time_valid = 1'b1;
        time_in    = 32'd6;
        tick();
        time_valid = 1'b0;
        load(32'd10, 16'd1);
        load(32'd11, 16'd2);
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; time_in = 32'd0; time_valid = 1'b0;
        load_valid = 1'b0; load_time = 32'd0; load_value = 16'd0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_value", v16(value_out), v16(16'd0));
        chk("rst_update", {31'd0, value_update}, 32'd0);
        chk("rst_pending", {29'd0, events_pending}, 32'd0);
        chk("rst_ready", {31'd0, load_ready}, 32'd1);
        chk("rst_late", {31'd0, late_error}, 32'd0);
        chk("rst_order", {31'd0, order_error}, 32'd0);

        // Basic replay
        load(32'd10, 16'd5);
        load(32'd20, 16'hFFFD);
        chk("basic_pending0", {29'd0, events_pending}, 32'd2);
        time_valid = 1'b1;
        for (int t = 0; t <= 25; t++) begin
            time_in = 32'(t);
            tick();
            upd_count += int'(value_update);
            chk("basic_value", v16(value_out),
                v16((t >= 20) ? 16'hFFFD : (t >= 10) ? 16'd5 : 16'd0));
            chk("basic_pending", {29'd0, events_pending},
                (t >= 20) ? 32'd0 : (t >= 10) ? 32'd1 : 32'd2);
            chk("basic_update", {31'd0, value_update}, (t == 10 || t == 20) ? 32'd1 : 32'd0);
        end
        time_valid = 1'b0;
        chk("basic_pulses", 32'(upd_count), 32'd2);

        // Full and wrap
        do_clear();
        for (int i = 0; i < 4; i++) begin
            load(32'(100 + i), 16'(1 + i));
        end
        chk("full_pending", {29'd0, events_pending}, 32'd4);
        chk("full_ready", {31'd0, load_ready}, 32'd0);
        for (int r = 0; r < 3; r++) begin
            load_valid = 1'b1;
            load_time  = 32'(104 + r);
            load_value = 16'(5 + r);
            tick();
            chk("wrap_reject", {29'd0, events_pending}, 32'd4);
            chk("wrap_ready0", {31'd0, load_ready}, 32'd0);
            time_valid = 1'b1;
            time_in    = 32'(100 + r);
            tick();
            time_valid = 1'b0;
            chk("wrap_popval", v16(value_out), v16(16'(1 + r)));
            chk("wrap_popcnt", {29'd0, events_pending}, 32'd3);
            chk("wrap_ready1", {31'd0, load_ready}, 32'd1);
            tick();
            load_valid = 1'b0;
            chk("wrap_accept", {29'd0, events_pending}, 32'd4);
        end
        time_valid = 1'b1;
        time_in    = 32'd200;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("wrap_drain", v16(value_out), v16(16'(4 + i)));
        end
        time_valid = 1'b0;
        chk("wrap_empty", {29'd0, events_pending}, 32'd0);

        // Late events
        do_clear();
        load(32'd10, 16'd1);
        load(32'd12, 16'd2);
        time_valid = 1'b1;
        time_in    = 32'd0;
        tick();
        chk("late_nopop", {29'd0, events_pending}, 32'd2);
        time_in = 32'd15;
        tick();
        chk("late_val1", v16(value_out), v16(16'd1));
        chk("late_flag", {31'd0, late_error}, 32'd1);
        tick();
        chk("late_val2", v16(value_out), v16(16'd2));
        chk("late_upd2", {31'd0, value_update}, 32'd1);
        chk("late_empty", {29'd0, events_pending}, 32'd0);
        time_valid = 1'b0;

        // Order error
        do_clear();
        chk("clr_late", {31'd0, late_error}, 32'd0);
        load(32'd30, 16'd11);
        load(32'd30, 16'd12);
        load(32'd40, 16'd13);
        chk("ord_flag", {31'd0, order_error}, 32'd1);
        chk("ord_pending", {29'd0, events_pending}, 32'd2);
        time_valid = 1'b1;
        time_in    = 32'd50;
        tick();
        chk("ord_val1", v16(value_out), v16(16'd11));
        tick();
        chk("ord_val2", v16(value_out), v16(16'd13));
        chk("ord_empty", {29'd0, events_pending}, 32'd0);
        time_valid = 1'b0;

        // Gating and simultaneous push/pop
        do_clear();
        load(32'd60, 16'd21);
        time_in = 32'd100;
        tick();
        tick();
        chk("gate_pending", {29'd0, events_pending}, 32'd1);
        chk("gate_value", v16(value_out), v16(16'd0));
        chk("gate_update", {31'd0, value_update}, 32'd0);
        time_valid = 1'b1;
        load(32'd70, 16'd22);
        time_valid = 1'b0;
        chk("sim_pending", {29'd0, events_pending}, 32'd1);
        chk("sim_value", v16(value_out), v16(16'd21));
        chk("sim_update", {31'd0, value_update}, 32'd1);

        // Clear with state built up; a load in the clear cycle is discarded
        build_dirty();
        chk("dirty_pending", {29'd0, events_pending}, 32'd3);
        chk("dirty_value", v16(value_out), v16(16'd7));
        chk("dirty_late", {31'd0, late_error}, 32'd1);
        chk("dirty_order", {31'd0, order_error}, 32'd1);
        clear      = 1'b1;
        load_valid = 1'b1;
        load_time  = 32'd50;
        load_value = 16'd3;
        tick();
        clear      = 1'b0;
        load_valid = 1'b0;
        chk("clr_pending", {29'd0, events_pending}, 32'd0);
        chk("clr_value", v16(value_out), v16(16'd0));
        chk("clr_lateflag", {31'd0, late_error}, 32'd0);
        chk("clr_orderflag", {31'd0, order_error}, 32'd0);
        chk("clr_ready", {31'd0, load_ready}, 32'd1);

        // Asynchronous reset mid-cycle
        build_dirty();
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_pending", {29'd0, events_pending}, 32'd0);
        chk("arst_value", v16(value_out), v16(16'd0));
        chk("arst_late", {31'd0, late_error}, 32'd0);
        chk("arst_order", {31'd0, order_error}, 32'd0);
        chk("arst_ready", {31'd0, load_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        load(32'd1, 16'd4);
        chk("arst_history", {29'd0, events_pending}, 32'd1);
        chk("arst_noorder", {31'd0, order_error}, 32'd0);

        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end

endmodule
